// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding I-cache request, IF/ID register with a one-entry skid and flush drop.
// Latency: acceptance to IF/ID valid is cache latency + 1 edge; ID stall parks a response in the skid and holds the PC.
module if_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                pc_stall,
    output logic                im_req,
    output logic [ADDR_W-1:0]   im_addr,
    input  logic                im_ready,
    input  logic                im_rvalid,
    input  logic [INST_W-1:0]   im_rdata,
    input  logic                id_stall,
    input  logic                flush,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [INST_W-1:0]   ifid_inst,
    output logic                ifid_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FULL = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_req_pc;
    logic [ADDR_W-1:0]   r_skid_pc;
    logic [INST_W-1:0]   r_skid_inst;
    logic [ADDR_W-1:0]   r_ifid_pc;
    logic [INST_W-1:0]   r_ifid_inst;
    logic                r_ifid_valid;

    logic                w_accept;
    logic                w_deliver;
    logic                w_skid_load;
    logic [ADDR_W-1:0]   w_dlv_pc;
    logic [INST_W-1:0]   w_dlv_inst;

    assign w_accept = (r_state == S_REQ) && im_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_deliver   = 1'b0;
        w_skid_load = 1'b0;
        w_dlv_pc    = r_skid_pc;
        w_dlv_inst  = r_skid_inst;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_accept) begin
                    w_state_nxt = flush ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_nxt = im_rvalid ? S_REQ : S_DROP;
                end else if (im_rvalid) begin
                    if (id_stall) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_FULL;
                    end else begin
                        w_deliver   = 1'b1;
                        w_dlv_pc    = r_req_pc;
                        w_dlv_inst  = im_rdata;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_FULL: begin
                if (flush) begin
                    w_state_nxt = S_REQ;
                end else if (!id_stall) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            // A flush while draining keeps dropping; the response itself still retires the fetch.
            S_DROP: begin
                if (im_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign im_req     = (r_state == S_REQ);
    assign im_addr    = pc_in;
    assign pc_stall   = !(w_deliver || flush);
    assign ifid_pc    = r_ifid_pc;
    assign ifid_inst  = r_ifid_inst;
    assign ifid_valid = r_ifid_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_pc    <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_pc <= pc_in;
            end
            if (w_skid_load) begin
                r_skid_pc   <= r_req_pc;
                r_skid_inst <= im_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_pc    <= '0;
        end else if (flush) begin
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
        end else if (id_stall) begin
            r_ifid_valid <= r_ifid_valid;
        end else if (w_deliver) begin
            r_ifid_valid <= 1'b1;
            r_ifid_inst  <= w_dlv_inst;
            r_ifid_pc    <= w_dlv_pc;
        end else begin
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
        end
    end

endmodule
